dcache_bank_ctrl: RTL
=====================

Name: dcache_bank_ctrl

Overview:
Sequencer and arbiter for one 128-word, byte-write-enable, single-write/async-read data bank of the D-cache. It shares the bank's single write port and single read port between three requesters:
- the CPU load/store port
- the AXI refill stream, which writes a whole line
- the AXI writeback stream, which reads out a whole victim line

It sits between the cache FSM and the bank, driving we/waddr/raddr/din.

Parameters:
ADDR_W, 7, bank word-address width (128 words)
LINE_WORDS, 8, words per line (power of two); OFS_W = log2(LINE_WORDS)
DATA_W, 32, word width; byte enables = DATA_W/8

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, asynchronous, active-high
cpu_req  in  1  CPU access valid this cycle
cpu_we  in  4  CPU byte write enables; 0 = load
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  CPU load data (combinational from bank)
cpu_stall  out  1  CPU access not accepted this cycle
refill_start  in  1  pulse: begin line refill
wb_start  in  1  pulse: begin line writeback
line_idx  in  ADDR_W-OFS_W  line to refill or write back; sampled with the start pulse
crit_ofs  in  OFS_W  first word offset of the refill; sampled with refill_start
r_valid  in  1  refill beat valid
r_data  in  DATA_W  refill beat data
r_last  in  1  final refill beat
r_ready  out  1  controller accepts refill beat
w_valid  out  1  writeback beat valid
w_data  out  DATA_W  writeback beat data
w_last  out  1  final writeback beat
w_ready  in  1  sink accepts writeback beat
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a refill or writeback completes
xfer_err  out  1  one-cycle pulse with done when r_last and the beat count disagree
ram_we  out  4  bank byte enables
ram_waddr  out  ADDR_W  bank write address
ram_raddr  out  ADDR_W  bank read address
ram_wdata  out  DATA_W  bank write data
ram_rdata  in  DATA_W  bank read data (async, write-forwarded)

Behaviour:
- FSM states: IDLE, REFILL, WB. Registers: state, line reg, beat counter cnt (OFS_W bits), beats-done count.
- Reset values: state=IDLE, cnt=0, done=0, xfer_err=0. Outputs r_ready, w_valid, w_last, ram_we and busy are 0 while in reset.
- IDLE:
  - cpu_req is served in the same cycle, cpu_stall=0.
  - ram_raddr=ram_waddr=cpu_addr, ram_we=cpu_req?cpu_we:0, ram_wdata=cpu_wdata, cpu_rdata=ram_rdata.
  - Load latency is 0 cycles; store commits at the clock edge.
- IDLE transitions:
  - wb_start → WB (wb_start wins if both starts arrive together; refill_start is dropped and the cache FSM must reissue it).
  - Else refill_start → REFILL.
  - cnt loads 0 for WB, crit_ofs for REFILL.
  - A cpu_req in the start cycle is still served.
- REFILL:
  - r_ready=1.
  - On r_valid: ram_we=4'hF, ram_waddr={line,cnt}, ram_wdata=r_data.
  - cnt increments mod LINE_WORDS (wrap-around); beats-done count increments.
- REFILL completion:
  - Finishes when the LINE_WORDS-th beat is accepted or r_last is accepted, whichever comes first → IDLE, done=1 next cycle.
  - xfer_err=1 if exactly one of those two conditions is true on the final beat.
- WB:
  - ram_raddr={line,cnt}, w_data=ram_rdata, w_valid=1, w_last=(cnt==LINE_WORDS-1).
  - On w_ready: cnt++.
  - Last beat accepted → IDLE, done=1.
  - w_data is held stable while w_valid && !w_ready.
- In REFILL and WB: cpu_stall=cpu_req. No CPU write is issued; cpu_rdata is don't-care.
- Start pulses outside IDLE are ignored.
- Asynchronous reset mid-transfer:
  - Immediately returns to IDLE.
  - done is not pulsed; the partial line contents are undefined.
  - The cache FSM must invalidate the line.

Optional Feature:
DCACHE_REFILL_BYPASS_EN
- Defined:
  - While in REFILL, a cpu_req load whose address equals {line,crit_ofs} is served on the cycle the critical beat is written.
  - cpu_rdata=r_data, cpu_stall=0 for that cycle.
  - Stores stay stalled.
- Undefined: all CPU accesses stall until IDLE.

Decomposition:
- Shared package dcache_pkg holds:
  - state enum {IDLE, REFILL, WB}
  - LINE_WORDS, OFS_W, ADDR_W, DATA_W
  - byte-enable width constant
- Optional sub-module dcache_beat_counter: wrapping OFS_W counter with load, enable, and terminal-count flag; instanced once.

Test Plan:
- IDLE store cpu_we=4'b0011, addr 7'h05, data 32'hAABBCCDD, then load 7'h05 → ram_we=0011 at the store; load returns 32'hxxxxCCDD in the same cycle with no stall.
- refill_start line_idx=3, crit_ofs=5, 8 beats D0..D7 with r_last on beat 8 → writes to addrs 0x1D,0x1E,0x1F,0x18..0x1C; done pulse; xfer_err=0.
- wb_start line_idx=2 with w_ready toggling 1,0,1,… → 8 beats from 0x10..0x17 in order; w_data is held while stalled; w_last only on 0x17; done once.
- r_last on beat 6 of 8 → FSM returns to IDLE; done=1, xfer_err=1.
- refill_start and wb_start in the same cycle → WB entered, refill ignored; cpu_req during WB → cpu_stall=1 every cycle.
- rst asserted mid-refill at beat 3 → busy=0 and r_ready=0 asynchronously; no done; the next refill works normally.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the D-cache data-bank controller.
package dcache_pkg;
  localparam int ADDR_W     = 7;
  localparam int LINE_WORDS = 8;
  localparam int OFS_W      = $clog2(LINE_WORDS);
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int LINE_W     = ADDR_W - OFS_W;

  typedef enum logic [1:0] {IDLE, REFILL, WB} state_e;
endpackage

// File: rtl/dcache_bank_ctrl_if.sv
// Bundle of CPU, refill, writeback and bank signals around dcache_bank_ctrl.
// master = cache FSM / AXI side / bank model, slave = the controller.
interface dcache_bank_ctrl_if;
  import dcache_pkg::*;

  logic              cpu_req;
  logic [BE_W-1:0]   cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              refill_start;
  logic              wb_start;
  logic [LINE_W-1:0] line_idx;
  logic [OFS_W-1:0]  crit_ofs;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_ready;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_last;
  logic              w_ready;
  logic              busy;
  logic              done;
  logic              xfer_err;
  logic [BE_W-1:0]   ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, refill_start, wb_start,
           line_idx, crit_ofs, r_valid, r_data, r_last, w_ready, ram_rdata,
    input  cpu_rdata, cpu_stall, r_ready, w_valid, w_data, w_last, busy,
           done, xfer_err, ram_we, ram_waddr, ram_raddr, ram_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, refill_start, wb_start,
           line_idx, crit_ofs, r_valid, r_data, r_last, w_ready, ram_rdata,
    output cpu_rdata, cpu_stall, r_ready, w_valid, w_data, w_last, busy,
           done, xfer_err, ram_we, ram_waddr, ram_raddr, ram_wdata
  );
endinterface

// File: rtl/dcache_beat_counter.sv
// Wrapping word-offset counter for line transfers; load wins over enable.
module dcache_beat_counter
  import dcache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [OFS_W-1:0] load_val,
  output logic [OFS_W-1:0] cnt,
  output logic             tc
);
  logic [OFS_W-1:0] cnt_d, cnt_q;

  // Wrap-around comes for free because LINE_WORDS is a power of two.
  always_comb begin
    cnt_d = cnt_q;
    if (load)    cnt_d = load_val;
    else if (en) cnt_d = cnt_q + OFS_W'(1);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == OFS_W'(LINE_WORDS - 1));
endmodule

// File: rtl/dcache_bank_ctrl.sv
// Arbitrates one D-cache data bank between CPU, line refill and line writeback.
// Optional: define DCACHE_REFILL_BYPASS_EN to serve the critical-word load during refill.
module dcache_bank_ctrl
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  dcache_bank_ctrl_if.slave  bus
);
  state_e            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [OFS_W:0]    beats_q, beats_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              cnt_load, cnt_en, cnt_tc, beat_full;
  logic [OFS_W-1:0]  cnt_load_val, cnt;
  logic [ADDR_W-1:0] beat_addr;
  logic              bypass_hit;

  dcache_beat_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_load_val),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  assign beat_addr = {line_q, cnt};

`ifdef DCACHE_REFILL_BYPASS_EN
  // The critical word is always the first beat, so beats_q==0 identifies it.
  assign bypass_hit = (state_q == REFILL) && bus.r_valid && (beats_q == '0) &&
                      bus.cpu_req && (bus.cpu_we == '0) && (bus.cpu_addr == beat_addr);
`else
  assign bypass_hit = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    beats_d       = beats_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    cnt_load      = 1'b0;
    cnt_load_val  = '0;
    cnt_en        = 1'b0;
    beat_full     = 1'b0;
    bus.cpu_rdata = bus.ram_rdata;
    bus.cpu_stall = bus.cpu_req;
    bus.r_ready   = 1'b0;
    bus.w_valid   = 1'b0;
    bus.w_last    = 1'b0;
    bus.w_data    = bus.ram_rdata;
    bus.ram_we    = '0;
    bus.ram_waddr = bus.cpu_addr;
    bus.ram_raddr = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;

    unique case (state_q)
      IDLE: begin
        bus.cpu_stall = 1'b0;
        if (bus.cpu_req) bus.ram_we = bus.cpu_we;
        // Writeback has priority; a simultaneous refill request is dropped.
        if (bus.wb_start) begin
          state_d  = WB;
          line_d   = bus.line_idx;
          beats_d  = '0;
          cnt_load = 1'b1;
        end else if (bus.refill_start) begin
          state_d      = REFILL;
          line_d       = bus.line_idx;
          beats_d      = '0;
          cnt_load     = 1'b1;
          cnt_load_val = bus.crit_ofs;
        end
      end
      REFILL: begin
        bus.r_ready   = 1'b1;
        bus.ram_waddr = beat_addr;
        bus.ram_wdata = bus.r_data;
        if (bus.r_valid) begin
          bus.ram_we = '1;
          cnt_en     = 1'b1;
          beats_d    = beats_q + 1'b1;
          beat_full  = (beats_q == (OFS_W + 1)'(LINE_WORDS - 1));
          if (beat_full || bus.r_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = beat_full ^ bus.r_last;
          end
        end
        if (bypass_hit) begin
          bus.cpu_rdata = bus.r_data;
          bus.cpu_stall = 1'b0;
        end
      end
      WB: begin
        bus.ram_raddr = beat_addr;
        bus.w_valid   = 1'b1;
        bus.w_last    = cnt_tc;
        if (bus.w_ready) begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Keep the bank quiet while reset is held, even if the CPU is requesting.
    if (rst) bus.ram_we = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      beats_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      beats_q <= beats_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.xfer_err = err_q;
endmodule
